// File: rtl/hdmi_out_fifo_reader.sv
// hdmi_out_fifo_reader: video timing generator that streams pixels from a FIFO and recovers from underflow at frame boundaries
module hdmi_out_fifo_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 10,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP = 110,
    parameter int H_SYNC = 40,
    parameter int H_BP = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP = 5,
    parameter int V_SYNC = 5,
    parameter int V_BP = 20,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1,
    parameter int START_LEVEL = 16,
    parameter logic [DATA_WIDTH-1:0] FILL_COLOR = '0
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_rd_level,
    output logic                  fifo_rd_en,
    output logic                  vid_hs,
    output logic                  vid_vs,
    output logic                  vid_de,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  frame_start,
    output logic                  underflow,
    output logic [15:0]           underflow_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    typedef enum logic [1:0] {WAIT_FILL, RUN, RESYNC} state_t;
    state_t state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic vid_hs_q, vid_hs_d, vid_vs_q, vid_vs_d, vid_de_q, vid_de_d;
    logic frame_start_q, frame_start_d, underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] vid_data_q, vid_data_d;
    logic [15:0] underflow_cnt_q, underflow_cnt_d;
    logic h_last, v_last, origin, active, hs_act, vs_act, running, uf_event;
    always_comb begin
        h_last = h_cnt_q == HW'(H_TOTAL - 1);
        v_last = v_cnt_q == VW'(V_TOTAL - 1);
        origin = h_cnt_q == '0 && v_cnt_q == '0;
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = h_last ? (v_last ? '0 : v_cnt_q + 1'b1) : v_cnt_q;
        active = h_cnt_q < HW'(H_ACTIVE) && v_cnt_q < VW'(V_ACTIVE);
        hs_act = h_cnt_q >= HW'(H_ACTIVE + H_FP) && h_cnt_q < HW'(H_ACTIVE + H_FP + H_SYNC);
        vs_act = v_cnt_q >= VW'(V_ACTIVE + V_FP) && v_cnt_q < VW'(V_ACTIVE + V_FP + V_SYNC);
        running = state_q == RUN;
        fifo_rd_en = running && active && !fifo_empty;
        uf_event = running && active && fifo_empty;
        state_d = state_q;
        case (state_q)
            WAIT_FILL: state_d = (origin && fifo_rd_level >= (ADDR_WIDTH + 1)'(START_LEVEL)) ? RUN : WAIT_FILL;
            RUN:       state_d = uf_event ? RESYNC : RUN;
            RESYNC:    state_d = (h_last && v_last) ? WAIT_FILL : RESYNC;
            default:   state_d = WAIT_FILL;
        endcase
        vid_de_d = active;
        vid_hs_d = hs_act ~^ HS_POL;
        vid_vs_d = vs_act ~^ VS_POL;
        vid_data_d = fifo_rd_en ? fifo_rd_data : FILL_COLOR;
        frame_start_d = running && origin;
        underflow_d = uf_event;
        underflow_cnt_d = (uf_event && underflow_cnt_q != 16'hFFFF) ? underflow_cnt_q + 16'd1 : underflow_cnt_q;
    end
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= WAIT_FILL;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            vid_de_q <= 1'b0;
            vid_hs_q <= ~HS_POL;
            vid_vs_q <= ~VS_POL;
            vid_data_q <= FILL_COLOR;
            frame_start_q <= 1'b0;
            underflow_q <= 1'b0;
            underflow_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            vid_de_q <= vid_de_d;
            vid_hs_q <= vid_hs_d;
            vid_vs_q <= vid_vs_d;
            vid_data_q <= vid_data_d;
            frame_start_q <= frame_start_d;
            underflow_q <= underflow_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end
    assign vid_de = vid_de_q;
    assign vid_hs = vid_hs_q;
    assign vid_vs = vid_vs_q;
    assign vid_data = vid_data_q;
    assign frame_start = frame_start_q;
    assign underflow = underflow_q;
    assign underflow_cnt = underflow_cnt_q;
endmodule

// File: tb/tb_hdmi_out_fifo_reader.sv
// tb_hdmi_out_fifo_reader: FIFO model plus per-cycle timing reference checking a small-timing instance
module tb_hdmi_out_fifo_reader;
    localparam logic [23:0] FILL = 24'h5A5A5A;
    logic rd_clk = 1'b0;
    logic rd_rst = 1'b0;
    logic [23:0] fifo_rd_data = '0;
    logic fifo_empty = 1'b1;
    logic [7:0] fifo_rd_level = '0;
    logic fifo_rd_en, vid_hs, vid_vs, vid_de, frame_start, underflow;
    logic [23:0] vid_data;
    logic [15:0] underflow_cnt;
    logic n_rd_en, n_hs, n_vs, n_de, n_fs, n_uf;
    logic [23:0] n_data;
    logic [15:0] n_cnt;
    hdmi_out_fifo_reader #(.DATA_WIDTH(24), .ADDR_WIDTH(7), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .START_LEVEL(8), .FILL_COLOR(FILL))
    dut (.rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_level(fifo_rd_level), .fifo_rd_en(fifo_rd_en), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .vid_data(vid_data), .frame_start(frame_start), .underflow(underflow), .underflow_cnt(underflow_cnt));
    hdmi_out_fifo_reader #(.DATA_WIDTH(24), .ADDR_WIDTH(7), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .START_LEVEL(8), .FILL_COLOR(FILL))
    dut_n (.rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_level(fifo_rd_level), .fifo_rd_en(n_rd_en), .vid_hs(n_hs), .vid_vs(n_vs), .vid_de(n_de),
        .vid_data(n_data), .frame_start(n_fs), .underflow(n_uf), .underflow_cnt(n_cnt));
    always #5 rd_clk = ~rd_clk;
    typedef struct {
        int preload;
        int cycles;
        int exp_rd;
        int exp_de;
        int exp_uf;
        int exp_fs;
        logic [15:0] exp_cnt;
    } vec_t;
    logic [23:0] q[$];
    int n_vec = 0, n_bad = 0, t = 0, m_state = 0;
    int cnt_rd, cnt_de, cnt_uf, cnt_fs;
    logic e_de, e_hs, e_vs, e_fs, e_uf;
    logic [23:0] e_data;
    logic [15:0] e_cnt;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got %0h want %0h", name, t, act, exp);
        end
    endtask
    task automatic drive();
        fifo_empty = q.size() == 0;
        fifo_rd_data = q.size() != 0 ? q[0] : 24'h0;
        fifo_rd_level = 8'(q.size());
    endtask
    task automatic do_reset(input int preload);
        rd_rst = 1'b1;
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_de", vid_de, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_cnt", underflow_cnt, 0);
        chk("rst_data", vid_data, FILL);
        chk("rst_hs", vid_hs, 0);
        chk("rst_vs", vid_vs, 0);
        chk("rst_hs_n", n_hs, 1);
        chk("rst_vs_n", n_vs, 1);
        if (preload >= 0) begin
            q.delete();
            for (int i = 1; i <= preload; i++) q.push_back(24'(i));
        end
        drive();
        @(negedge rd_clk);
        rd_rst = 1'b0;
        #1;
        t = 0;
        m_state = 0;
        e_cnt = '0;
        cnt_rd = 0; cnt_de = 0; cnt_uf = 0; cnt_fs = 0;
    endtask
    task automatic tick(input int push_pct);
        int h, v;
        bit act, hs_a, vs_a, run, emp, exp_en, ev, pop;
        h = t % 14;
        v = (t / 14) % 7;
        act = h < 8 && v < 4;
        hs_a = h >= 10 && h < 12;
        vs_a = v == 5;
        run = m_state == 1;
        emp = q.size() == 0;
        exp_en = run && act && !emp;
        ev = run && act && emp;
        chk("rd_en", fifo_rd_en, exp_en);
        pop = fifo_rd_en;
        if (pop) cnt_rd++;
        e_de = act;
        e_hs = hs_a;
        e_vs = vs_a;
        e_data = exp_en ? q[0] : FILL;
        e_fs = run && h == 0 && v == 0;
        e_uf = ev;
        if (ev && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        if (m_state == 0 && h == 0 && v == 0 && q.size() >= 8) m_state = 1;
        else if (ev) m_state = 2;
        else if (m_state == 2 && h == 13 && v == 6) m_state = 0;
        @(posedge rd_clk);
        if (pop && q.size() != 0) void'(q.pop_front());
        if (int'($urandom_range(99)) < push_pct && q.size() < 120) q.push_back(24'($urandom));
        #1;
        drive();
        #1;
        chk("de", vid_de, e_de);
        chk("hs", vid_hs, e_hs);
        chk("vs", vid_vs, e_vs);
        chk("hs_n", n_hs, {~e_hs});
        chk("vs_n", n_vs, {~e_vs});
        chk("data", vid_data, e_data);
        chk("frame_start", frame_start, e_fs);
        chk("underflow", underflow, e_uf);
        chk("uf_cnt", underflow_cnt, e_cnt);
        if (vid_de) cnt_de++;
        if (underflow) cnt_uf++;
        if (frame_start) cnt_fs++;
        t++;
    endtask
    vec_t vecs[3];
    initial begin
        vecs[0] = '{preload: 4, cycles: 294, exp_rd: 0, exp_de: 96, exp_uf: 0, exp_fs: 0, exp_cnt: 16'd0};
        vecs[1] = '{preload: 40, cycles: 196, exp_rd: 40, exp_de: 64, exp_uf: 1, exp_fs: 1, exp_cnt: 16'd1};
        vecs[2] = '{preload: 10, cycles: 196, exp_rd: 10, exp_de: 64, exp_uf: 1, exp_fs: 0, exp_cnt: 16'd1};
        #3;
        for (int i = 0; i < 3; i++) begin
            do_reset(vecs[i].preload);
            for (int c = 0; c < vecs[i].cycles; c++) tick(0);
            chk("case_rd", cnt_rd, vecs[i].exp_rd);
            chk("case_de", cnt_de, vecs[i].exp_de);
            chk("case_uf", cnt_uf, vecs[i].exp_uf);
            chk("case_fs", cnt_fs, vecs[i].exp_fs);
            chk("case_cnt", underflow_cnt, vecs[i].exp_cnt);
        end
        // reset asserted mid-line while streaming, then restart with words still queued
        do_reset(40);
        for (int c = 0; c < 30; c++) tick(0);
        chk("pre_rst_de", vid_de, 1);
        do_reset(-1);
        chk("post_rst_rd_en", fifo_rd_en, 0);
        for (int c = 0; c < 98; c++) tick(0);
        chk("post_rst_fs", cnt_fs, 0);
        // counter saturation
        do_reset(0);
        tick(0);
        force dut.underflow_cnt_q = 16'hFFFD;
        #1;
        release dut.underflow_cnt_q;
        e_cnt = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 8; w++) q.push_back(24'($urandom));
            drive();
            #1;
            for (int c = 0; c < 196; c++) tick(0);
        end
        chk("sat_uf", cnt_uf, 4);
        chk("sat_cnt", underflow_cnt, 16'hFFFF);
        // random traffic
        do_reset(int'($urandom_range(0, 60)));
        for (int s = 0; s < 4; s++) begin
            int pct;
            pct = int'($urandom_range(10, 60));
            for (int c = 0; c < 750; c++) tick(pct);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
